seg_display_driver: RTL and testbench

- Multi-digit seven-segment display driver. It accepts a binary value on a load strobe and converts it to BCD sequentially (shift-add-3 / double-dabble, one bit per clock), or splits it into hex nibbles.
- Drives NUM_DIGITS active-low digit outputs. Adds leading-zero blanking, an overflow indication and per-digit blinking.
- Sits between game/score logic (mine counter, timer) and the DE1 HEX pins. Generalises the single-digit combinational decoder.

---
 rtl/seg_display_driver.sv | 210 +++++++++++++++++++++
 tb/tb_seg_display_driver.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// Multi-digit seven-segment driver: sequential binary-to-BCD (double dabble) or hex split,
// with leading-zero blanking, overflow dashes, per-digit blinking and a registered HEX stage.
module seg_display_driver #(
    parameter int WIDTH      = 10,
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [WIDTH-1:0]        value,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] HEX
);

    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int ACC_W = DIG_W + 4;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    function automatic logic [6:0] seg_lut(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        shift_q, shift_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sticky_q, sticky_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;
    logic [BLK_W-1:0]        blink_cnt_q;
    logic                    phase_q;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    logic [ACC_W-1:0]        adj;
    logic [ACC_W-1:0]        acc_shift;
    logic                    guard_prev;
    logic                    guard_new;
    logic                    dec_ovf;
    logic [DIG_W-1:0]        hex_digits;
    logic                    hex_ovf;

    // Add-3 correction on every nibble, guard nibble included.
    for (genvar gi = 0; gi <= NUM_DIGITS; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                          : acc_q[4*gi +: 4];
    end

    assign acc_shift  = {adj[ACC_W-2:0], shift_q[WIDTH-1]};
    assign guard_prev = (acc_q[ACC_W-1 -: 4] != 4'd0);
    assign guard_new  = (acc_shift[ACC_W-1 -: 4] != 4'd0);
    // A nonzero guard at any step already implies overflow; the sticky bit keeps it
    // even if later guard bits are shifted out of the accumulator.
    assign dec_ovf    = sticky_q | guard_prev | adj[ACC_W-1] | guard_new;

    if (WIDTH > DIG_W) begin : g_hex_wide
        assign hex_digits = value[DIG_W-1:0];
        assign hex_ovf    = |value[WIDTH-1:DIG_W];
    end else if (WIDTH == DIG_W) begin : g_hex_equal
        assign hex_digits = value;
        assign hex_ovf    = 1'b0;
    end else begin : g_hex_narrow
        assign hex_digits = {{(DIG_W-WIDTH){1'b0}}, value};
        assign hex_ovf    = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        digit_d  = digit_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    if (hex_mode) begin
                        digit_d = hex_digits;
                        ovf_d   = hex_ovf;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        shift_d  = value;
                        acc_d    = '0;
                        cnt_d    = '0;
                        sticky_d = 1'b0;
                        state_d  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d    = acc_shift;
                shift_d  = shift_q << 1;
                sticky_d = sticky_q | guard_prev | adj[ACC_W-1];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    digit_d = acc_shift[DIG_W-1:0];
                    ovf_d   = dec_ovf;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            digit_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Built from the next digit register so HEX changes on the same edge as done.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic       lz;
        logic       blank;
        logic [6:0] seg;
        if (gi == 0) begin : g_lsd
            assign lz = 1'b0;
        end else begin : g_upper
            assign lz = (digit_d[DIG_W-1:4*gi] == '0);
        end
        assign blank = ~valid_d | (~ovf_d & blank_lz & lz) | (phase_q & blink_en[gi]);
        assign seg   = ovf_d ? SEG_DASH : seg_lut(digit_d[4*gi +: 4]);
        assign hex_d[7*gi +: 7] = blank ? SEG_BLANK : seg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q <= '1;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign overflow = ovf_q;
    assign HEX      = hex_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: a 4-digit and a 2-digit instance share stimulus and are
// compared against a positional-arithmetic display model.
module tb_seg_display_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [9:0]  value = '0;
    logic        hex_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_en = '0;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [27:0] hex_a;
    logic [13:0] hex_b;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int m_v = 0;
    bit m_hexm = 1'b0;
    bit m_valid = 1'b0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] BLNK = 7'b1111111;

    seg_display_driver #(.WIDTH(10), .NUM_DIGITS(4), .BLINK_DIV(4)) u_dut_a (
        .clk(clk), .reset(reset), .load(load), .value(value), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy_a), .done(done_a),
        .overflow(ovf_a), .HEX(hex_a));

    seg_display_driver #(.WIDTH(10), .NUM_DIGITS(2), .BLINK_DIV(3)) u_dut_b (
        .clk(clk), .reset(reset), .load(load), .value(value), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .blink_en(blink_en[1:0]), .busy(busy_b), .done(done_b),
        .overflow(ovf_b), .HEX(hex_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    // HEX seen n edges after reset reflects the blink phase after n-1 edges.
    function automatic bit phase_of(input int n, input int div);
        if (n < 1) return 1'b0;
        return 1'(((n - 1) / div) % 2);
    endfunction

    function automatic logic [27:0] model_hex(input int nd, input int v, input bit hm,
                                              input bit valid, input bit blz,
                                              input logic [3:0] ben, input bit ph);
        logic [27:0] r;
        logic [6:0]  seg;
        int base, lim, pw;
        bit ovf;
        r = '1;
        if (!valid) return r;
        base = hm ? 16 : 10;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * base;
        ovf = (v >= lim);
        pw = 1;
        for (int k = 0; k < nd; k++) begin
            if (ovf)                      seg = DASH;
            else if (k > 0 && blz && v < pw) seg = BLNK;
            else                          seg = seg_tab[(v / pw) % base];
            if (ph && ben[k]) seg = BLNK;
            r[7*k +: 7] = seg;
            pw = pw * base;
        end
        return r;
    endfunction

    function automatic bit model_ovf(input int nd);
        int lim;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * (m_hexm ? 16 : 10);
        return m_valid && (m_v >= lim);
    endfunction

    function automatic logic [27:0] exp_a();
        return model_hex(4, m_v, m_hexm, m_valid, blank_lz, blink_en, phase_of(ecnt, 4));
    endfunction

    function automatic logic [13:0] exp_b();
        logic [27:0] r;
        r = model_hex(2, m_v, m_hexm, m_valid, blank_lz, blink_en, phase_of(ecnt, 3));
        return r[13:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int v, input bit hm);
        value = 10'(v);
        hex_mode = hm;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Ends in the done cycle with the model updated.
    task automatic finish_conv(input int v, input bit hm);
        start_load(v, hm);
        if (!hm) repeat (10) tick();
        m_v = v;
        m_hexm = hm;
        m_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_valid = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", ovf_a); end
        checks++; if (hex_a !== 28'hFFFFFFF) begin errors++; $display("FAIL reset_hex_a got %h expected fffffff", hex_a); end
        checks++; if (hex_b !== 14'h3FFF) begin errors++; $display("FAIL reset_hex_b got %h expected 3fff", hex_b); end
    endtask

    task automatic test_decimal_937();
        blank_lz = 1'b1;
        blink_en = '0;
        start_load(937, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                errors++; $display("FAIL dec937_busy cycle %0d got busy=%b done=%b expected busy=1 done=0", c, busy_a, done_a);
            end
            checks++; if (hex_a !== 28'hFFFFFFF) begin
                errors++; $display("FAIL dec937_hold cycle %0d got %h expected fffffff", c, hex_a);
            end
            tick();
        end
        m_v = 937; m_hexm = 1'b0; m_valid = 1'b1;
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL dec937_done got busy=%b done=%b expected busy=0 done=1", busy_a, done_a);
        end
        checks++; if (hex_a !== {BLNK, 7'b0010000, 7'b0110000, 7'b1111000}) begin
            errors++; $display("FAIL dec937_hex_a got %h expected %h", hex_a, {BLNK, 7'b0010000, 7'b0110000, 7'b1111000});
        end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL dec937_ovf_a got %b expected 0", ovf_a); end
        checks++; if (ovf_b !== 1'b1 || hex_b !== {DASH, DASH}) begin
            errors++; $display("FAIL dec937_b got ovf=%b hex=%h expected ovf=1 hex=%h", ovf_b, hex_b, {DASH, DASH});
        end
        tick();
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL dec937_done_pulse got %b expected 0", done_a); end
    endtask

    task automatic test_zero();
        blank_lz = 1'b1;
        finish_conv(0, 1'b0);
        checks++; if (hex_a !== {BLNK, BLNK, BLNK, 7'b1000000}) begin
            errors++; $display("FAIL zero_lz got %h expected %h", hex_a, {BLNK, BLNK, BLNK, 7'b1000000});
        end
        tick();
        blank_lz = 1'b0;
        tick();
        checks++; if (hex_a !== {4{7'b1000000}}) begin
            errors++; $display("FAIL zero_nolz got %h expected %h", hex_a, {4{7'b1000000}});
        end
        checks++; if (hex_b !== {2{7'b1000000}}) begin
            errors++; $display("FAIL zero_nolz_b got %h expected %h", hex_b, {2{7'b1000000}});
        end
    endtask

    task automatic test_hex();
        blank_lz = 1'b0;
        finish_conv(10'h2AF, 1'b1);
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL hex_latency got busy=%b done=%b expected busy=0 done=1", busy_a, done_a);
        end
        checks++; if (hex_a !== {7'b1000000, 7'b0100100, 7'b0001000, 7'b0001110}) begin
            errors++; $display("FAIL hex_2af got %h expected %h", hex_a, {7'b1000000, 7'b0100100, 7'b0001000, 7'b0001110});
        end
        checks++; if (ovf_b !== 1'b1 || hex_b !== {DASH, DASH}) begin
            errors++; $display("FAIL hex_2af_b got ovf=%b hex=%h expected ovf=1 hex=%h", ovf_b, hex_b, {DASH, DASH});
        end
        tick();
        blank_lz = 1'b1;
        finish_conv(0, 1'b1);
        checks++; if (hex_a !== {BLNK, BLNK, BLNK, 7'b1000000}) begin
            errors++; $display("FAIL hex_zero_lz got %h expected %h", hex_a, {BLNK, BLNK, BLNK, 7'b1000000});
        end
        tick();
    endtask

    task automatic test_overflow_nd2();
        blank_lz = 1'b0;
        finish_conv(100, 1'b0);
        checks++; if (ovf_b !== 1'b1 || hex_b !== {DASH, DASH}) begin
            errors++; $display("FAIL ovf100_b got ovf=%b hex=%h expected ovf=1 hex=%h", ovf_b, hex_b, {DASH, DASH});
        end
        checks++; if (ovf_a !== 1'b0 || hex_a !== exp_a()) begin
            errors++; $display("FAIL ovf100_a got ovf=%b hex=%h expected ovf=0 hex=%h", ovf_a, hex_a, exp_a());
        end
        tick();
        finish_conv(99, 1'b0);
        checks++; if (ovf_b !== 1'b0 || hex_b !== {7'b0010000, 7'b0010000}) begin
            errors++; $display("FAIL ovf99_b got ovf=%b hex=%h expected ovf=0 hex=%h", ovf_b, hex_b, {7'b0010000, 7'b0010000});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        blank_lz = 1'b1;
        start_load(937, 1'b0);
        tick();
        tick();
        value = 10'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b expected 1", busy_a); end
        checks++; if (hex_a !== exp_a()) begin errors++; $display("FAIL b2b_hold got %h expected %h", hex_a, exp_a()); end
        repeat (7) tick();
        m_v = 937; m_hexm = 1'b0; m_valid = 1'b1;
        checks++; if (done_a !== 1'b1 || hex_a !== exp_a()) begin
            errors++; $display("FAIL b2b_result got done=%b hex=%h expected done=1 hex=%h", done_a, hex_a, exp_a());
        end
        // Load held high from the done cycle: ignored in DONE, restarts from IDLE.
        value = 10'd12;
        load = 1'b1;
        tick();
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++; $display("FAIL held_idle got busy=%b done=%b expected 0 0", busy_a, done_a);
        end
        tick();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL held_restart got %b expected 1", busy_a); end
        repeat (10) tick();
        load = 1'b0;
        m_v = 12;
        checks++; if (done_a !== 1'b1 || hex_a !== exp_a()) begin
            errors++; $display("FAIL held_result got done=%b hex=%h expected done=1 hex=%h", done_a, hex_a, exp_a());
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int done_seen;
        start_load(5, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_valid = 1'b0;
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL abort_ctrl got busy=%b done=%b ovf=%b expected 0 0 0", busy_a, done_a, ovf_a);
        end
        checks++; if (hex_a !== 28'hFFFFFFF) begin errors++; $display("FAIL abort_hex got %h expected fffffff", hex_a); end
        done_seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done_a === 1'b1 || busy_a === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles expected 0", done_seen); end
        checks++; if (hex_a !== 28'hFFFFFFF) begin errors++; $display("FAIL abort_hex_after got %h expected fffffff", hex_a); end
    endtask

    task automatic test_blink();
        int on_cnt, off_cnt;
        blank_lz = 1'b1;
        blink_en = 4'b0001;
        finish_conv(12, 1'b0);
        on_cnt = 0;
        off_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            checks++; if (hex_a !== exp_a()) begin
                errors++; $display("FAIL blink_a cycle %0d got %h expected %h", c, hex_a, exp_a());
            end
            checks++; if (hex_a[13:7] !== 7'b1111001) begin
                errors++; $display("FAIL blink_steady cycle %0d got %b expected 1111001", c, hex_a[13:7]);
            end
            checks++; if (hex_b !== exp_b()) begin
                errors++; $display("FAIL blink_b cycle %0d got %h expected %h", c, hex_b, exp_b());
            end
            if (hex_a[6:0] === BLNK) off_cnt++;
            if (hex_a[6:0] === 7'b0100100) on_cnt++;
            tick();
        end
        checks++; if (on_cnt != 8 || off_cnt != 8) begin
            errors++; $display("FAIL blink_duty got on=%0d off=%0d expected on=8 off=8", on_cnt, off_cnt);
        end
        blink_en = '0;
    endtask

    task automatic test_random();
        int v;
        bit hm;
        for (int it = 0; it < 40; it++) begin
            v = int'($urandom_range(0, 1023));
            hm = 1'($urandom_range(0, 1));
            blank_lz = 1'($urandom_range(0, 1));
            blink_en = 4'($urandom);
            finish_conv(v, hm);
            checks++; if (done_a !== 1'b1 || done_b !== 1'b1) begin
                errors++; $display("FAIL rnd_done v=%0d hm=%0d got %b%b expected 11", v, hm, done_a, done_b);
            end
            checks++; if (hex_a !== exp_a() || ovf_a !== model_ovf(4)) begin
                errors++; $display("FAIL rnd_a v=%0d hm=%0d got %h/%b expected %h/%b", v, hm, hex_a, ovf_a, exp_a(), model_ovf(4));
            end
            checks++; if (hex_b !== exp_b() || ovf_b !== model_ovf(2)) begin
                errors++; $display("FAIL rnd_b v=%0d hm=%0d got %h/%b expected %h/%b", v, hm, hex_b, ovf_b, exp_b(), model_ovf(2));
            end
            tick();
            blank_lz = 1'($urandom_range(0, 1));
            blink_en = 4'($urandom);
            tick();
            checks++; if (hex_a !== exp_a() || hex_b !== exp_b()) begin
                errors++; $display("FAIL rnd_live v=%0d got %h/%h expected %h/%h", v, hex_a, hex_b, exp_a(), exp_b());
            end
        end
    endtask

    initial begin
        test_reset();
        test_decimal_937();
        test_zero();
        test_hex();
        test_overflow_nd2();
        test_back_to_back();
        test_reset_abort();
        test_blink();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
